// File: rtl/draw_pkg.sv
// Shared types and constants for the tile-draw sequencer: op codes, FSM states
// and the packed request word carried through the FIFO.
package draw_pkg;

  typedef enum logic [1:0] {
    OP_DRAW  = 2'b00,
    OP_ERASE = 2'b01,
    OP_WIN   = 2'b10,
    OP_LOSE  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ARM  = 3'd2,
    PLOT = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam int TILE_DIM = 16;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    op_e        op;
  } req_t;

  localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/draw_control_if.sv
// Valid/ready request channel from game logic into the draw sequencer.
interface draw_control_if;

  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_x;
  logic [3:0] req_y;
  logic [1:0] req_op;

  modport master (
    output req_valid,
    output req_x,
    output req_y,
    output req_op,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_x,
    input  req_y,
    input  req_op,
    output req_ready
  );

endinterface

// File: rtl/draw_req_fifo.sv
// Synchronous request FIFO without bypass: a push becomes visible at the head
// one cycle later. Pointers wrap naturally because DEPTH is a power of two.
module draw_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];

  // Storage array; left unreset since reads are gated by the occupancy count.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/draw_control.sv
// Tile-draw sequencer: buffers requests and replays each one to the datapath
// as LOAD (coordinate latch), ARM, then PLOT_CYCLES cycles of pixel writes.
module draw_control
  import draw_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int PLOT_CYCLES = TILE_DIM * TILE_DIM
) (
  input  logic           clock,
  input  logic           reset_n,
  draw_control_if.slave  req,
  output logic [3:0]     x_out,
  output logic [3:0]     y_out,
  output logic           update,
  output logic           draw_game,
  output logic           erase,
  output logic           draw_win,
  output logic           draw_lose,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  localparam int CNT_W = $clog2(PLOT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PLOT_CYCLES - 1);

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] cnt_r;
  req_t             req_r;
  logic             pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [REQ_W-1:0] fifo_head_s;

  draw_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (req.req_valid),
    .push_data ({req.req_x, req.req_y, req.req_op}),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign req.req_ready = ~fifo_full_s;

  // Next-state logic; the FIFO head is popped exactly when entering LOAD.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          state_s = LOAD;
          pop_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: state_s = ARM;
      ARM:  state_s = PLOT;
      PLOT: begin
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
        end else begin
          state_s = PLOT;
        end
      end
      DONE: begin
        if (!fifo_empty_s) begin
          state_s = LOAD;
          pop_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request register, reloaded on every pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_r <= req_t'({REQ_W{1'b0}});
    end else if (pop_s) begin
      req_r <= req_t'(fifo_head_s);
    end else begin
      req_r <= req_r;
    end
  end

  // Plot counter: cleared in ARM so PLOT starts at 0, saturates at the last pixel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ARM) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == PLOT) && (cnt_r != CNT_LAST)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Output decode from registered state and request only.
  always_comb begin
    update    = 1'b0;
    draw_game = 1'b0;
    erase     = 1'b0;
    draw_win  = 1'b0;
    draw_lose = 1'b0;
    plot      = 1'b0;
    done      = 1'b0;
    case (state_r)
      LOAD: update = 1'b1;
      ARM, PLOT: begin
        plot = (state_r == PLOT);
        case (req_r.op)
          OP_DRAW:  draw_game = 1'b1;
          OP_ERASE: erase     = 1'b1;
          OP_WIN:   draw_win  = 1'b1;
          OP_LOSE:  draw_lose = 1'b1;
          default:  draw_game = 1'b0;
        endcase
      end
      DONE:    done   = 1'b1;
      default: update = 1'b0;
    endcase
  end

  assign busy  = (state_r != IDLE) | ~fifo_empty_s;
  assign x_out = req_r.x;
  assign y_out = req_r.y;

endmodule
